// File: rtl/idli_trace_m.sv
// PC/stall trace capture: assembles a nibble-serial PC and queues {pc, stalls} records on each completed instruction.
// A record is visible one cycle after its push; it holds while i_trace_rdy is low, and a push into a full FIFO without a pop is dropped and counted.
module idli_trace_m #(
    parameter int NIB_W   = 4,
    parameter int WORD_W  = 16,
    parameter int PC_OFS  = 1,
    parameter int DEPTH   = 8,
    parameter int STALL_W = 8
) (
    input  logic               i_trace_gck,
    input  logic               i_trace_rst_n,
    input  logic               i_trace_en,
    input  logic [NIB_W-1:0]   i_trace_nib,
    input  logic               i_trace_instr_done,
    input  logic               i_trace_stall,
    output logic               o_trace_vld,
    input  logic               i_trace_rdy,
    output logic [WORD_W-1:0]  o_trace_pc,
    output logic [STALL_W-1:0] o_trace_stalls,
    output logic               o_trace_ovf,
    output logic [STALL_W-1:0] o_trace_drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [WORD_W-1:0]  pc;
        logic [STALL_W-1:0] stalls;
    } rec_t;

    logic [WORD_W-1:0]  pc_q, pc_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [STALL_W-1:0] drop_q, drop_d;

    rec_t               mem [DEPTH];
    rec_t               wr_rec;
    rec_t               rd_rec;
    logic [STALL_W-1:0] rec_stalls;
    logic               push, pop, full, wr_en, drop;

    always_comb begin
        pc_d       = {i_trace_nib, pc_q[WORD_W-1:NIB_W]};
        rec_stalls = stall_q;
        if (i_trace_stall && !(&stall_q)) begin
            rec_stalls = stall_q + STALL_W'(1);
        end
        // The counter restarts on every completed instruction, traced or not.
        stall_d       = i_trace_instr_done ? '0 : rec_stalls;
        wr_rec.pc     = pc_d - WORD_W'(PC_OFS);
        wr_rec.stalls = rec_stalls;
    end

    assign push  = i_trace_instr_done & i_trace_en;
    assign pop   = o_trace_vld & i_trace_rdy;
    assign full  = (cnt_q == CNT_W'(DEPTH));
    // When full, a concurrent pop frees the slot the write lands in.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q | drop;
        drop_d   = drop_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !wr_en) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (drop && !(&drop_q)) begin
            drop_d = drop_q + STALL_W'(1);
        end
    end

    always_ff @(posedge i_trace_gck or negedge i_trace_rst_n) begin
        if (!i_trace_rst_n) begin
            pc_q     <= '0;
            stall_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            stall_q  <= stall_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge i_trace_gck) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_rec;
        end
    end

    // Storage is not reset, so the outputs are masked to zero while empty.
    assign rd_rec           = mem[rd_ptr_q];
    assign o_trace_vld      = (cnt_q != '0);
    assign o_trace_pc       = o_trace_vld ? rd_rec.pc : '0;
    assign o_trace_stalls   = o_trace_vld ? rd_rec.stalls : '0;
    assign o_trace_ovf      = ovf_q;
    assign o_trace_drop_cnt = drop_q;
endmodule
